// File: rtl/multi_channel_producer_pkg.sv
// Shared types and defaults for the multi-channel producer: default widths and flush FSM encoding.
package multi_channel_producer_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_ID_WIDTH      = 8;
    localparam int CHAN_SEL_W        = 4;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_WAIT  = 2'd1,
        FLUSH_ISSUE = 2'd2
    } flush_state_e;

endpackage

// File: rtl/multi_channel_producer_channel.sv
// One producer lane: stride-stepped address and channel-tagged sequence ID, advancing on advance_i.
module producer_channel #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int ID_WIDTH      = 8,
    parameter int SEQ_WIDTH     = 4,
    parameter int ADDR_STRIDE   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          advance_i,
    input  logic [ID_WIDTH-SEQ_WIDTH-1:0] tag_i,
    output logic [ADDRESS_WIDTH-1:0]      addr_o,
    output logic [ID_WIDTH-1:0]           id_o,
    output logic                          valid_o
);

    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [SEQ_WIDTH-1:0]     seq_q, seq_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic                     valid_q;

    // Sequence wraps inside its own field; the tag is never carried into.
    always_comb begin
        addr_d = addr_q + ADDRESS_WIDTH'(ADDR_STRIDE);
        seq_d  = seq_q + SEQ_WIDTH'(1);
        id_d   = {tag_i, seq_d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            seq_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else if (advance_i) begin
            addr_q  <= addr_d;
            seq_q   <= seq_d;
            id_q    <= id_d;
            valid_q <= 1'b1;
        end
    end

    assign addr_o  = addr_q;
    assign id_o    = id_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/multi_channel_producer.sv
// N-channel transaction generator with a programmable, optionally delayed flush command port.
module multi_channel_producer
    import multi_channel_producer_pkg::*;
#(
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int ID_WIDTH      = DEF_ID_WIDTH,
    parameter int SEQ_WIDTH     = 4,
    parameter int ADDR_STRIDE   = 4,
    parameter int DELAY_WIDTH   = 6
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic [NUM_CHANNELS-1:0]            in_stall,
    output logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] out_address,
    output logic [NUM_CHANNELS*ID_WIDTH-1:0]   out_id,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    output logic [NUM_CHANNELS-1:0]            flush,
    output logic [NUM_CHANNELS*ID_WIDTH-1:0]   flush_id,
    input  logic                               flush_cmd_valid,
    output logic                               flush_cmd_ready,
    input  logic [CHAN_SEL_W-1:0]              flush_cmd_chan,
    input  logic [ID_WIDTH-1:0]                flush_cmd_id,
    input  logic [DELAY_WIDTH-1:0]             flush_cmd_delay,
    output logic                               flush_err
);

    localparam int TAG_W = ID_WIDTH - SEQ_WIDTH;
    localparam logic [CHAN_SEL_W-1:0] NCH = CHAN_SEL_W'(NUM_CHANNELS);

    flush_state_e                     state_q, state_d;
    logic [DELAY_WIDTH-1:0]           cnt_q, cnt_d;
    logic [CHAN_SEL_W-1:0]            chan_q, chan_d;
    logic [ID_WIDTH-1:0]              fid_q, fid_d;
    logic                             err_q, err_d;
    logic [NUM_CHANNELS-1:0]          flush_q, flush_d;
    logic [NUM_CHANNELS*ID_WIDTH-1:0] flush_id_q, flush_id_d;
    logic [NUM_CHANNELS-1:0]          hold;

    assign flush_cmd_ready = (state_q == FLUSH_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        fid_d   = fid_q;
        err_d   = 1'b0;
        case (state_q)
            FLUSH_IDLE: begin
                if (flush_cmd_valid) begin
                    chan_d = flush_cmd_chan;
                    fid_d  = flush_cmd_id;
                    if (flush_cmd_chan >= NCH) begin
                        err_d = 1'b1;
                    end else if (flush_cmd_delay == '0) begin
                        state_d = FLUSH_ISSUE;
                    end else begin
                        state_d = FLUSH_WAIT;
                        cnt_d   = flush_cmd_delay;
                    end
                end
            end
            FLUSH_WAIT: begin
                cnt_d = cnt_q - DELAY_WIDTH'(1);
                if (cnt_q == DELAY_WIDTH'(1)) state_d = FLUSH_ISSUE;
            end
            FLUSH_ISSUE: state_d = FLUSH_IDLE;
            default:     state_d = FLUSH_IDLE;
        endcase
    end

    // Pulse outputs are registered from the next state so they line up with the ISSUE cycle.
    always_comb begin
        flush_d    = '0;
        flush_id_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_d == FLUSH_ISSUE && chan_d == CHAN_SEL_W'(c)) begin
                flush_d[c]                          = 1'b1;
                flush_id_d[c*ID_WIDTH +: ID_WIDTH]  = fid_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FLUSH_IDLE;
            cnt_q      <= '0;
            chan_q     <= '0;
            fid_q      <= '0;
            err_q      <= 1'b0;
            flush_q    <= '0;
            flush_id_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            fid_q      <= fid_d;
            err_q      <= err_d;
            flush_q    <= flush_d;
            flush_id_q <= flush_id_d;
        end
    end

    assign flush     = flush_q;
    assign flush_id  = flush_id_q;
    assign flush_err = err_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        assign hold[g] = (state_q == FLUSH_ISSUE) && (chan_q == CHAN_SEL_W'(g));

        producer_channel #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .ID_WIDTH      (ID_WIDTH),
            .SEQ_WIDTH     (SEQ_WIDTH),
            .ADDR_STRIDE   (ADDR_STRIDE)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .advance_i (enable && !in_stall[g] && !hold[g]),
            .tag_i     (TAG_W'(g + 1)),
            .addr_o    (out_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .id_o      (out_id[g*ID_WIDTH +: ID_WIDTH]),
            .valid_o   (out_valid[g])
        );
    end

endmodule
